// File: rtl/stage3_scheduler_pkg.sv
// Shared types and default sizing for the stage3 arcsine scheduler.
package stage3_sched_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        RECOVER = 2'd3
    } state_t;

    localparam int OP_W_DEF    = 16;
    localparam int ASIN_W_DEF  = 12;
    localparam int TIMEOUT_DEF = 64;
    localparam int RST_CYC_DEF = 2;

endpackage

// File: rtl/stage3_scheduler_arb.sv
// Round-robin arbiter: search starts one past the last accepted grant.
module rr_arbiter #(
    parameter int N     = 3,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clock,
    input  logic             rst,
    input  logic [N-1:0]     pending,
    input  logic             accept,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any
);

    logic [IDX_W-1:0] start;
    logic [IDX_W:0]   pos;

    always_ff @(posedge clock) begin
        if (rst) begin
            start <= '0;
        end else if (accept) begin
            start <= (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        pos       = '0;
        for (int unsigned k = 0; k < N; k++) begin
            pos = {1'b0, start} + (IDX_W + 1)'(k);
            if (pos >= (IDX_W + 1)'(N)) begin
                pos = pos - (IDX_W + 1)'(N);
            end
            if (!any && pending[pos[IDX_W-1:0]]) begin
                any                     = 1'b1;
                grant[pos[IDX_W-1:0]]   = 1'b1;
                grant_idx               = pos[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/stage3_scheduler.sv
// Time-shares one stage3 arcsine unit between N_CH requesters, with a
// watchdog that resets stage3 when valid never arrives.
module stage3_scheduler
    import stage3_sched_pkg::*;
#(
    parameter int N_CH    = 3,
    parameter int OP_W    = OP_W_DEF,
    parameter int ASIN_W  = ASIN_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int RST_CYC = RST_CYC_DEF
) (
    input  logic                   clock,
    input  logic                   rst,
    input  logic [N_CH-1:0]        req,
    input  logic [N_CH*OP_W-1:0]   L_in,
    input  logic [N_CH*OP_W-1:0]   magMN_in,
    output logic [N_CH-1:0]        busy,
    output logic [N_CH-1:0]        done,
    output logic [N_CH-1:0]        err,
    output logic [N_CH*ASIN_W-1:0] asin_out,
    output logic                   s3_enable,
    output logic                   s3_rst,
    output logic [OP_W-1:0]        s3_L,
    output logic [OP_W-1:0]        s3_magMN,
    input  logic [ASIN_W-1:0]      s3_asin,
    input  logic                   s3_valid
);

    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam int RC_W  = $clog2(RST_CYC + 1);

    state_t                 state, state_nx;
    logic [N_CH-1:0]        pending;
    logic [N_CH*OP_W-1:0]   hold_l, hold_m;
    logic [IDX_W-1:0]       cur;
    logic [CNT_W-1:0]       wcnt;
    logic [RC_W-1:0]        rcnt;
    logic [N_CH-1:0]        grant, svc;
    logic [IDX_W-1:0]       grant_idx;
    logic                   any, accept;

    rr_arbiter #(.N(N_CH), .IDX_W(IDX_W)) u_arb (
        .clock     (clock),
        .rst       (rst),
        .pending   (pending),
        .accept    (accept),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (any)
    );

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        case (state)
            IDLE: begin
                if (any) begin
                    state_nx = ISSUE;
                    accept   = 1'b1;
                end
            end
            ISSUE:   state_nx = WAIT;
            WAIT: begin
                if (s3_valid) begin
                    state_nx = IDLE;
                end else if (wcnt == CNT_W'(TIMEOUT - 1)) begin
                    state_nx = RECOVER;
                end
            end
            RECOVER: begin
                if (rcnt == RC_W'(RST_CYC - 1)) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        svc = '0;
        if (state != IDLE) begin
            svc[cur] = 1'b1;
        end
    end

    assign busy      = pending | svc;
    assign s3_enable = (state == ISSUE);
    assign s3_rst    = rst | (state == RECOVER);

    always_ff @(posedge clock) begin
        if (rst) begin
            state    <= IDLE;
            pending  <= '0;
            hold_l   <= '0;
            hold_m   <= '0;
            cur      <= '0;
            wcnt     <= '0;
            rcnt     <= '0;
            done     <= '0;
            err      <= '0;
            asin_out <= '0;
            s3_L     <= '0;
            s3_magMN <= '0;
        end else begin
            state <= state_nx;
            done  <= '0;
            for (int unsigned i = 0; i < N_CH; i++) begin
                if (req[i]) begin
                    hold_l[i*OP_W +: OP_W] <= L_in[i*OP_W +: OP_W];
                    hold_m[i*OP_W +: OP_W] <= magMN_in[i*OP_W +: OP_W];
                end
            end
            // A req landing on the grant edge re-arms pending for the next round.
            pending <= (pending & ~(grant & {N_CH{accept}})) | req;
            if (accept) begin
                cur      <= grant_idx;
                s3_L     <= hold_l[grant_idx*OP_W +: OP_W];
                s3_magMN <= hold_m[grant_idx*OP_W +: OP_W];
            end
            case (state)
                ISSUE: wcnt <= '0;
                WAIT: begin
                    rcnt <= '0;
                    if (s3_valid) begin
                        asin_out[cur*ASIN_W +: ASIN_W] <= s3_asin;
                        err[cur]  <= 1'b0;
                        done[cur] <= 1'b1;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                RECOVER: begin
                    if (rcnt == RC_W'(RST_CYC - 1)) begin
                        err[cur]  <= 1'b1;
                        done[cur] <= 1'b1;
                    end else begin
                        rcnt <= rcnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_stage3_scheduler.sv
// Directed self-checking bench for stage3_scheduler with a stage3 stub
// (valid 8 cycles after enable, asin = magMN[11:0] - L[11:0]).
module tb_stage3_scheduler;

    logic        clock = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  req = '0;
    logic [47:0] L_in = '0;
    logic [47:0] magMN_in = '0;
    logic [2:0]  busy, done, err;
    logic [35:0] asin_out;
    logic        s3_enable, s3_rst;
    logic [15:0] s3_L, s3_magMN;
    logic [11:0] s3_asin;
    logic        s3_valid;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    logic        stub_valid = 1'b0;
    logic [11:0] stub_asin = '0;
    int          stub_cnt = 0;
    logic        stub_dead = 1'b0;
    logic        force_valid = 1'b0;

    int          en_cyc[$];
    logic [15:0] en_l[$];
    logic [15:0] en_m[$];
    int          done_cnt[3];
    int          done_cyc[3];
    int          rst_cnt = 0;
    int          rst_first = 0;

    stage3_scheduler #(
        .N_CH(3), .OP_W(16), .ASIN_W(12), .TIMEOUT(64), .RST_CYC(2)
    ) dut (
        .clock     (clock),
        .rst       (rst),
        .req       (req),
        .L_in      (L_in),
        .magMN_in  (magMN_in),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .asin_out  (asin_out),
        .s3_enable (s3_enable),
        .s3_rst    (s3_rst),
        .s3_L      (s3_L),
        .s3_magMN  (s3_magMN),
        .s3_asin   (s3_asin),
        .s3_valid  (s3_valid)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Stub deliberately ignores s3_rst so a late valid can follow a scheduler reset.
    always @(posedge clock) begin
        stub_valid <= 1'b0;
        if (s3_enable) begin
            stub_cnt  <= 7;
            stub_asin <= s3_magMN[11:0] - s3_L[11:0];
        end else if (stub_cnt != 0) begin
            stub_cnt <= stub_cnt - 1;
            if (stub_cnt == 1 && !stub_dead) stub_valid <= 1'b1;
        end
    end
    assign s3_valid = stub_valid | force_valid;
    assign s3_asin  = stub_asin;

    always @(negedge clock) begin
        if (s3_enable) begin
            en_cyc.push_back(cyc);
            en_l.push_back(s3_L);
            en_m.push_back(s3_magMN);
        end
        for (int i = 0; i < 3; i++) begin
            if (done[i]) begin
                done_cnt[i]++;
                done_cyc[i] = cyc;
            end
        end
        if (s3_rst && !rst) begin
            if (rst_cnt == 0) rst_first = cyc;
            rst_cnt++;
        end
    end

    function automatic logic [11:0] asin_of(input int ch);
        return asin_out[ch*12 +: 12];
    endfunction

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_mon();
        en_cyc.delete();
        en_l.delete();
        en_m.delete();
        for (int i = 0; i < 3; i++) begin
            done_cnt[i] = 0;
            done_cyc[i] = 0;
        end
        rst_cnt = 0;
        rst_first = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        force_valid = 1'b0;
        stub_dead = 1'b0;
        run(10);
        rst = 1'b0;
        clear_mon();
    endtask

    task automatic send_req(input int ch, input logic [15:0] l, input logic [15:0] m);
        L_in[ch*16 +: 16] = l;
        magMN_in[ch*16 +: 16] = m;
        req[ch] = 1'b1;
        tick();
        req = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        run(3);
        tests++; if (s3_rst !== 1'b1) begin fails++; $display("FAIL reset_s3_rst: got %b expected 1", s3_rst); end
        tests++; if ({busy, done, err} !== 9'd0) begin fails++; $display("FAIL reset_flags: got %b expected 0", {busy, done, err}); end
        tests++; if (asin_out !== 36'd0) begin fails++; $display("FAIL reset_asin: got %h expected 0", asin_out); end
        tests++; if ({s3_enable, s3_L, s3_magMN} !== 33'd0) begin fails++; $display("FAIL reset_s3_regs: got %h expected 0", {s3_enable, s3_L, s3_magMN}); end
        rst = 1'b0;
        tick();
        tests++; if (s3_rst !== 1'b0) begin fails++; $display("FAIL reset_release: s3_rst got %b expected 0", s3_rst); end
    endtask

    task automatic test_single();
        int k;
        do_reset();
        k = cyc;
        send_req(0, 16'd1166, 16'd6087);
        run(20);
        tests++; if (en_cyc.size() != 1) begin fails++; $display("FAIL single_en_count: got %0d expected 1", en_cyc.size()); end
        if (en_cyc.size() >= 1) begin
            tests++; if (en_cyc[0] != k + 2) begin fails++; $display("FAIL single_issue_cycle: got %0d expected %0d", en_cyc[0], k + 2); end
            tests++; if (en_l[0] !== 16'd1166 || en_m[0] !== 16'd6087) begin fails++; $display("FAIL single_operands: got %0d/%0d expected 1166/6087", en_l[0], en_m[0]); end
        end
        tests++; if (s3_L !== 16'd1166 || s3_magMN !== 16'd6087) begin fails++; $display("FAIL single_operand_hold: got %0d/%0d expected 1166/6087", s3_L, s3_magMN); end
        tests++; if (done_cnt[0] != 1) begin fails++; $display("FAIL single_done_count: got %0d expected 1", done_cnt[0]); end
        tests++; if (done_cyc[0] != k + 11) begin fails++; $display("FAIL single_done_cycle: got %0d expected %0d", done_cyc[0], k + 11); end
        tests++; if (asin_of(0) !== 12'd825) begin fails++; $display("FAIL single_asin: got %0d expected 825", asin_of(0)); end
        tests++; if (err !== 3'b000 || busy !== 3'b000) begin fails++; $display("FAIL single_err_busy: got %b/%b expected 000/000", err, busy); end
    endtask

    task automatic test_contention();
        do_reset();
        L_in = {16'd300, 16'd200, 16'd100};
        magMN_in = {16'd1000, 16'd1000, 16'd1000};
        req = 3'b111;
        tick();
        req = '0;
        tests++; if (busy !== 3'b111) begin fails++; $display("FAIL contention_busy: got %b expected 111", busy); end
        run(40);
        tests++; if (en_cyc.size() != 3) begin fails++; $display("FAIL contention_en_count: got %0d expected 3", en_cyc.size()); end
        if (en_cyc.size() == 3) begin
            tests++; if (en_l[0] !== 16'd100 || en_l[1] !== 16'd200 || en_l[2] !== 16'd300) begin fails++; $display("FAIL contention_order: got %0d,%0d,%0d expected 100,200,300", en_l[0], en_l[1], en_l[2]); end
            tests++; if (en_cyc[1] - en_cyc[0] != 10 || en_cyc[2] - en_cyc[1] != 10) begin fails++; $display("FAIL contention_spacing: got %0d,%0d expected 10,10", en_cyc[1] - en_cyc[0], en_cyc[2] - en_cyc[1]); end
        end
        tests++; if (asin_out !== {12'd700, 12'd800, 12'd900}) begin fails++; $display("FAIL contention_asin: got %h expected %h", asin_out, {12'd700, 12'd800, 12'd900}); end
        tests++; if (done_cnt[0] != 1 || done_cnt[1] != 1 || done_cnt[2] != 1) begin fails++; $display("FAIL contention_done: got %0d,%0d,%0d expected 1,1,1", done_cnt[0], done_cnt[1], done_cnt[2]); end
    endtask

    task automatic test_fairness();
        int seen;
        int ch;
        do_reset();
        L_in[15:0] = 16'd10;
        L_in[47:32] = 16'd30;
        magMN_in = {16'd1000, 16'd1000, 16'd1000};
        req = 3'b101;
        tick();
        req = '0;
        seen = 0;
        // Re-request the channel in service so both stay pending at each decision.
        for (int i = 0; i < 80; i++) begin
            tick();
            if (en_l.size() > seen) begin
                seen = en_l.size();
                if (seen <= 2) begin
                    ch = (en_l[seen-1] == 16'd10) ? 0 : 2;
                    req[ch] = 1'b1;
                    tick();
                    req = '0;
                end
            end
        end
        tests++; if (en_l.size() != 4) begin fails++; $display("FAIL fairness_count: got %0d expected 4", en_l.size()); end
        if (en_l.size() == 4) begin
            tests++; if (en_l[0] !== 16'd10 || en_l[1] !== 16'd30 || en_l[2] !== 16'd10 || en_l[3] !== 16'd30) begin fails++; $display("FAIL fairness_order: got %0d,%0d,%0d,%0d expected 10,30,10,30", en_l[0], en_l[1], en_l[2], en_l[3]); end
        end
    endtask

    task automatic test_timeout();
        int e0;
        do_reset();
        send_req(1, 16'd100, 16'd1000);
        run(15);
        tests++; if (asin_of(1) !== 12'd900 || err[1] !== 1'b0) begin fails++; $display("FAIL timeout_prior: got %0d err %b expected 900 err 0", asin_of(1), err[1]); end
        stub_dead = 1'b1;
        clear_mon();
        send_req(1, 16'd50, 16'd2000);
        run(80);
        e0 = (en_cyc.size() > 0) ? en_cyc[0] : -1000;
        tests++; if (en_cyc.size() != 1) begin fails++; $display("FAIL timeout_en_count: got %0d expected 1", en_cyc.size()); end
        tests++; if (rst_cnt != 2) begin fails++; $display("FAIL timeout_rst_len: got %0d expected 2", rst_cnt); end
        tests++; if (rst_first != e0 + 65) begin fails++; $display("FAIL timeout_rst_start: got %0d expected %0d", rst_first, e0 + 65); end
        tests++; if (done_cnt[1] != 1 || done_cyc[1] != e0 + 67) begin fails++; $display("FAIL timeout_done: got %0d at %0d expected 1 at %0d", done_cnt[1], done_cyc[1], e0 + 67); end
        tests++; if (err !== 3'b010) begin fails++; $display("FAIL timeout_err: got %b expected 010", err); end
        tests++; if (asin_of(1) !== 12'd900) begin fails++; $display("FAIL timeout_asin_kept: got %0d expected 900", asin_of(1)); end
        stub_dead = 1'b0;
        clear_mon();
        send_req(1, 16'd0, 16'd5);
        run(15);
        tests++; if (asin_of(1) !== 12'd5 || err[1] !== 1'b0 || done_cnt[1] != 1) begin fails++; $display("FAIL timeout_recover: got %0d err %b done %0d expected 5 err 0 done 1", asin_of(1), err[1], done_cnt[1]); end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        send_req(0, 16'd100, 16'd1000);
        for (int i = 0; i < 5 && en_cyc.size() == 0; i++) tick();
        tests++; if (en_cyc.size() != 1) begin fails++; $display("FAIL midrst_issue: got %0d enables expected 1", en_cyc.size()); end
        send_req(2, 16'd300, 16'd1000);
        run(2);
        rst = 1'b1;
        tick();
        tests++; if (busy !== 3'b000 || done !== 3'b000) begin fails++; $display("FAIL midrst_flags: got busy %b done %b expected 000/000", busy, done); end
        tests++; if (s3_rst !== 1'b1 || s3_enable !== 1'b0) begin fails++; $display("FAIL midrst_s3: got rst %b en %b expected 1/0", s3_rst, s3_enable); end
        rst = 1'b0;
        clear_mon();
        run(20);
        tests++; if (en_cyc.size() != 0 || done_cnt[0] + done_cnt[1] + done_cnt[2] != 0) begin fails++; $display("FAIL midrst_quiet: got %0d enables %0d dones expected 0/0", en_cyc.size(), done_cnt[0] + done_cnt[1] + done_cnt[2]); end
        tests++; if (asin_out !== 36'd0 || err !== 3'b000 || busy !== 3'b000) begin fails++; $display("FAIL midrst_state: got asin %h err %b busy %b expected 0", asin_out, err, busy); end
    endtask

    task automatic test_stale_valid();
        do_reset();
        force_valid = 1'b1;
        run(3);
        force_valid = 1'b0;
        run(2);
        tests++; if (done_cnt[0] + done_cnt[1] + done_cnt[2] != 0 || asin_out !== 36'd0) begin fails++; $display("FAIL stale_idle: got %0d dones asin %h expected 0/0", done_cnt[0] + done_cnt[1] + done_cnt[2], asin_out); end
        send_req(2, 16'd300, 16'd1000);
        for (int i = 0; i < 5 && en_cyc.size() == 0; i++) tick();
        force_valid = 1'b1;
        tick();
        force_valid = 1'b0;
        run(15);
        tests++; if (en_cyc.size() != 1 || done_cnt[2] != 1) begin fails++; $display("FAIL stale_issue_count: got %0d enables %0d dones expected 1/1", en_cyc.size(), done_cnt[2]); end
        if (en_cyc.size() == 1) begin
            tests++; if (done_cyc[2] != en_cyc[0] + 9) begin fails++; $display("FAIL stale_issue_timing: got %0d expected %0d", done_cyc[2], en_cyc[0] + 9); end
        end
        tests++; if (asin_of(2) !== 12'd700) begin fails++; $display("FAIL stale_issue_asin: got %0d expected 700", asin_of(2)); end
    endtask

    initial begin
        clear_mon();
        tick();
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_timeout();
        test_reset_mid_wait();
        test_stale_valid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
